// File: rtl/seg_display_arbiter_pkg.sv
// Shared constants for the seven-segment display arbiter: menu codes,
// seconds limits and the ownership FSM encoding.
package seg_disp_pkg;

   localparam logic [11:0] MENU_INPUT = 12'd100;
   localparam logic [11:0] MENU_GEN   = 12'd200;
   localparam logic [11:0] MENU_DISP  = 12'd300;
   localparam logic [11:0] MENU_CALC  = 12'd400;
   localparam logic [11:0] MENU_OP1   = 12'd410;
   localparam logic [11:0] MENU_OP2   = 12'd420;
   localparam logic [11:0] MENU_OP3   = 12'd430;
   localparam logic [11:0] MENU_OP4   = 12'd440;
   localparam logic [11:0] MENU_OP5   = 12'd450;

   localparam logic [7:0]  SEC_MAX    = 8'd99;
   localparam int          SEC_EN_BIT = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_OWNED = 2'd1,
      ST_OPEN  = 2'd2
   } arb_state_e;

   // The display has only two seconds digits, so larger values clamp.
   function automatic logic [7:0] sat_sec(input logic [7:0] sec);
      if (sec > SEC_MAX) begin
         return SEC_MAX;
      end else begin
         return sec;
      end
   endfunction

endpackage

// File: rtl/seg_display_arbiter_hold_timer.sv
// Down-counter that measures the minimum ownership window; zero_o marks
// the point where the current owner becomes preemptable.
module hold_timer #(
   parameter int CNT_W = 26
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             dec_i,
   output logic             zero_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Load has priority over decrement; decrement stops at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/seg_display_arbiter.sv
// Arbitrates ownership of the seven-segment display between requesters,
// enforcing a minimum hold per owner; lower index wins.
module seg_display_arbiter
   import seg_disp_pkg::*;
#(
   parameter int          NUM_REQ     = 3,
   parameter int          HOLD_CYCLES = 50_000_000,
   parameter int          CNT_W       = 26,
   parameter logic [11:0] IDLE_CODE   = MENU_INPUT
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_REQ-1:0]    req_i,
   input  logic [12*NUM_REQ-1:0] code_i,
   input  logic [8*NUM_REQ-1:0]  sec_i,
   input  logic [NUM_REQ-1:0]    sec_en_i,
   output logic [11:0]           menu_state_o,
   output logic [8:0]            seconds_o,
   output logic [NUM_REQ-1:0]    grant_o,
   output logic                  hold_active_o,
   output logic                  switch_pulse_o
);

   localparam arb_state_e       GRANT_ST = (HOLD_CYCLES == 1) ? ST_OPEN : ST_OWNED;
   localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYCLES - 1);

   arb_state_e         state_q, state_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [11:0]        menu_q, menu_d;
   logic [8:0]         sec_q, sec_d;
   logic               hold_q, hold_d;
   logic               pulse_q, pulse_d;

   logic [NUM_REQ-1:0] pend_s, pick_s, first_s, higher_s, higher_pick_s;
   logic               owner_req_s, load_s, dec_s, zero_s;

   hold_timer #(.CNT_W(CNT_W)) u_hold_timer (
      .clk        (clk),
      .reset      (reset),
      .load_i     (load_s),
      .load_val_i (HOLD_LD),
      .dec_i      (dec_s),
      .zero_o     (zero_s)
   );

   // Next grant/state; x & -x isolates the lowest set bit (highest priority).
   always_comb begin
      pend_s        = req_i & ~grant_q;
      pick_s        = pend_s & (~pend_s + NUM_REQ'(1));
      first_s       = req_i & (~req_i + NUM_REQ'(1));
      higher_s      = req_i & (grant_q - NUM_REQ'(1));
      higher_pick_s = higher_s & (~higher_s + NUM_REQ'(1));
      owner_req_s   = |(req_i & grant_q);
      state_d       = state_q;
      grant_d       = grant_q;
      load_s        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (|req_i) begin
               grant_d = first_s;
               load_s  = 1'b1;
               state_d = GRANT_ST;
            end else begin
               grant_d = '0;
            end
         end
         ST_OWNED, ST_OPEN: begin
            if (!owner_req_s) begin
               if (|pend_s) begin
                  grant_d = pick_s;
                  load_s  = 1'b1;
                  state_d = GRANT_ST;
               end else begin
                  grant_d = '0;
                  state_d = ST_IDLE;
               end
            end else if ((state_q == ST_OWNED) && !zero_s) begin
               state_d = ST_OWNED;
            end else if (|higher_s) begin
               grant_d = higher_pick_s;
               load_s  = 1'b1;
               state_d = GRANT_ST;
            end else begin
               state_d = ST_OPEN;
            end
         end
         default: begin
            grant_d = '0;
            state_d = ST_IDLE;
         end
      endcase
      dec_s = (state_q == ST_OWNED) && !load_s;
   end

   // Payload follows the owner chosen on this edge so grant and data move together.
   always_comb begin
      menu_d = IDLE_CODE;
      sec_d  = 9'd0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (grant_d[k]) begin
            menu_d             = code_i[12*k +: 12];
            sec_d[SEC_EN_BIT]  = sec_en_i[k];
            sec_d[7:0]         = sat_sec(sec_i[8*k +: 8]);
         end else begin
            sec_d = sec_d;
         end
      end
      hold_d  = (state_d == ST_OWNED);
      pulse_d = (grant_d != grant_q);
   end

   // Output and state registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         menu_q  <= IDLE_CODE;
         sec_q   <= 9'd0;
         hold_q  <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         menu_q  <= menu_d;
         sec_q   <= sec_d;
         hold_q  <= hold_d;
         pulse_q <= pulse_d;
      end
   end

   assign grant_o        = grant_q;
   assign menu_state_o   = menu_q;
   assign seconds_o      = sec_q;
   assign hold_active_o  = hold_q;
   assign switch_pulse_o = pulse_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Table-driven bench for seg_display_arbiter with HOLD_CYCLES=4; expected
// outputs are queued when a vector is driven and checked one cycle later.
module tb_seg_display_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  req_i;
   logic [35:0] code_i;
   logic [23:0] sec_i;
   logic [2:0]  sec_en_i;
   logic [11:0] menu_state_o;
   logic [8:0]  seconds_o;
   logic [2:0]  grant_o;
   logic        hold_active_o;
   logic        switch_pulse_o;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [2:0]  req;
      logic [7:0]  sec1;
      logic [2:0]  grant;
      logic [11:0] menu;
      logic [8:0]  secs;
      logic        hold;
      logic        pulse;
   } vec_t;

   typedef struct packed {
      logic [2:0]  grant;
      logic [11:0] menu;
      logic [8:0]  secs;
      logic        hold;
      logic        pulse;
   } exp_t;

   localparam int NV = 20;
   vec_t vecs [NV];
   exp_t sb_q [$];

   seg_display_arbiter #(
      .NUM_REQ     (3),
      .HOLD_CYCLES (4),
      .CNT_W       (4),
      .IDLE_CODE   (12'd100)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .req_i          (req_i),
      .code_i         (code_i),
      .sec_i          (sec_i),
      .sec_en_i       (sec_en_i),
      .menu_state_o   (menu_state_o),
      .seconds_o      (seconds_o),
      .grant_o        (grant_o),
      .hold_active_o  (hold_active_o),
      .switch_pulse_o (switch_pulse_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input exp_t e);
      check({tag, " grant"}, 12'(grant_o), 12'(e.grant));
      check({tag, " menu"},  menu_state_o, e.menu);
      check({tag, " secs"},  12'(seconds_o), 12'(e.secs));
      check({tag, " hold"},  12'(hold_active_o), 12'(e.hold));
      check({tag, " pulse"}, 12'(switch_pulse_o), 12'(e.pulse));
   endtask

   initial begin
      exp_t e;
      // client0: code 450, sec 10, en 0; client1: code 300, sec varies, en 1; client2: code 200, sec 5, en 1
      vecs[0]  = '{3'b000, 8'd0,   3'b000, 12'd100, 9'h000, 1'b0, 1'b0};
      vecs[1]  = '{3'b100, 8'd0,   3'b100, 12'd200, 9'h105, 1'b1, 1'b1};
      vecs[2]  = '{3'b101, 8'd0,   3'b100, 12'd200, 9'h105, 1'b1, 1'b0};
      vecs[3]  = '{3'b101, 8'd0,   3'b100, 12'd200, 9'h105, 1'b1, 1'b0};
      vecs[4]  = '{3'b101, 8'd0,   3'b100, 12'd200, 9'h105, 1'b1, 1'b0};
      vecs[5]  = '{3'b101, 8'd0,   3'b001, 12'd450, 9'h00A, 1'b1, 1'b1};
      vecs[6]  = '{3'b011, 8'd150, 3'b001, 12'd450, 9'h00A, 1'b1, 1'b0};
      vecs[7]  = '{3'b010, 8'd150, 3'b010, 12'd300, 9'h163, 1'b1, 1'b1};
      vecs[8]  = '{3'b010, 8'd99,  3'b010, 12'd300, 9'h163, 1'b1, 1'b0};
      vecs[9]  = '{3'b010, 8'd0,   3'b010, 12'd300, 9'h100, 1'b1, 1'b0};
      vecs[10] = '{3'b010, 8'd150, 3'b010, 12'd300, 9'h163, 1'b1, 1'b0};
      vecs[11] = '{3'b110, 8'd150, 3'b010, 12'd300, 9'h163, 1'b0, 1'b0};
      vecs[12] = '{3'b110, 8'd150, 3'b010, 12'd300, 9'h163, 1'b0, 1'b0};
      vecs[13] = '{3'b000, 8'd150, 3'b000, 12'd100, 9'h000, 1'b0, 1'b1};
      vecs[14] = '{3'b000, 8'd150, 3'b000, 12'd100, 9'h000, 1'b0, 1'b0};
      vecs[15] = '{3'b010, 8'd20,  3'b010, 12'd300, 9'h114, 1'b1, 1'b1};
      vecs[16] = '{3'b000, 8'd20,  3'b000, 12'd100, 9'h000, 1'b0, 1'b1};
      vecs[17] = '{3'b010, 8'd20,  3'b010, 12'd300, 9'h114, 1'b1, 1'b1};
      vecs[18] = '{3'b101, 8'd20,  3'b001, 12'd450, 9'h00A, 1'b1, 1'b1};
      vecs[19] = '{3'b001, 8'd20,  3'b001, 12'd450, 9'h00A, 1'b1, 1'b0};

      code_i   = {12'd200, 12'd300, 12'd450};
      sec_i    = {8'd5, 8'd0, 8'd10};
      sec_en_i = 3'b110;
      req_i    = 3'b111;
      reset    = 1'b1;

      // Requests held high during reset must not leak through.
      e = '{3'b000, 12'd100, 9'h000, 1'b0, 1'b0};
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check_all("reset", e);
      end
      reset = 1'b0;

      for (int i = 0; i < NV; i++) begin
         req_i = vecs[i].req;
         sec_i = {8'd5, vecs[i].sec1, 8'd10};
         sb_q.push_back('{vecs[i].grant, vecs[i].menu, vecs[i].secs, vecs[i].hold, vecs[i].pulse});
         @(negedge clk);
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard empty at vec %0d", i);
         end else begin
            e = sb_q.pop_front();
            check_all($sformatf("vec%0d", i), e);
         end
      end
      check("sb drained", 12'(sb_q.size()), 12'd0);

      // Asynchronous reset in the middle of a hold window.
      #2 reset = 1'b1;
      #1;
      e = '{3'b000, 12'd100, 9'h000, 1'b0, 1'b0};
      check_all("async_rst", e);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check_all("post_rst", e);
      @(negedge clk);
      e = '{3'b001, 12'd450, 9'h00A, 1'b1, 1'b1};
      check_all("regrant", e);
      @(negedge clk);
      e = '{3'b001, 12'd450, 9'h00A, 1'b1, 1'b0};
      check_all("regrant_hold", e);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
